// File: rtl/fetch_pc_unit_pkg.sv
// fetch_pc_unit_pkg: shared fetch constants, FSM state type and redirect target adder
package fetch_pc_unit_pkg;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] INSTR_BYTES = 32'd4;
  typedef enum logic {RUN, FLUSH} fetch_state_e;
  function automatic logic [31:0] calc_target(input logic [31:0] base, input logic [31:0] off, input logic jalr);
    logic [31:0] t;
    t = base + off;
    return {t[31:1], t[0] & ~jalr};
  endfunction
endpackage

// File: rtl/fetch_pc_unit_if.sv
// fetch_pc_unit_if: instruction-memory request/response and decode hand-off signals
interface fetch_pc_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  modport master (
    output imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready
  );
  modport slave (
    input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready
  );
endinterface

// File: rtl/fetch_pc_unit_fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush; push and pop may coincide even when full
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic                  i_flush,
  input  logic [W-1:0]          i_data,
  output logic [W-1:0]          o_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_count;
  assign o_data  = r_mem[r_rd];
  assign o_full  = r_count == FULL_C;
  assign o_empty = ~|r_count;
  assign o_count = r_count;
  always_ff @(posedge clk)
    if (i_push) r_mem[r_wr] <= i_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      r_wr    <= r_wr + AW'(i_push);
      r_rd    <= r_rd + AW'(i_pop);
      r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
    end
endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: owns the PC, issues credit-limited imem fetches and discards stale responses after redirects
module fetch_pc_unit import fetch_pc_unit_pkg::*; #(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_pc_new,
  input  logic [31:0] i_pc_base,
  input  logic [31:0] i_pc_offset,
  input  logic        i_jalr,
  input  logic        i_fetch_en,
  output logic        o_target_misaligned,
  fetch_pc_unit_if.master bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  fetch_state_e  r_state;
  fetch_state_e  w_state_nx;
  logic [31:0]   r_pc;
  logic [CW-1:0] r_out;
  logic [CW-1:0] r_drop;
  logic [CW-1:0] w_drop_nx;
  logic          r_misaligned;
  logic [31:0]   w_target;
  logic [31:0]   w_rsp_pc;
  logic          w_fire;
  logic          w_push;
  logic          w_pop;
  logic          w_empty;
  logic          w_full;
  logic [CW-1:0] w_count;
  logic          w_pcq_full;
  logic          w_pcq_empty;
  logic [CW-1:0] w_pcq_count;
  logic          w_unused;
  assign w_target = calc_target(i_pc_base, i_pc_offset, i_jalr);
  // outstanding requests plus buffered entries never exceed the buffer, so responses always have a slot
  assign bus.imem_req_valid = rst_n & i_fetch_en & ~i_pc_new & (r_out + w_count < DEPTH_C);
  assign bus.imem_req_addr  = r_pc;
  assign w_fire   = bus.imem_req_valid & bus.imem_req_ready;
  assign w_push   = bus.imem_rsp_valid & (r_state == RUN) & ~i_pc_new;
  assign bus.if_valid = ~w_empty & ~i_pc_new;
  assign w_pop    = bus.if_valid & bus.if_ready;
  assign o_target_misaligned = r_misaligned;
  assign w_unused = ^{w_full, w_pcq_full, w_pcq_empty, w_pcq_count};
  // stale responses are counted off in FLUSH; new-path requests are tracked only by the PC queue
  always_comb begin
    w_drop_nx  = r_drop;
    w_state_nx = r_state;
    if (i_pc_new) begin
      w_drop_nx  = r_out - CW'(bus.imem_rsp_valid);
      w_state_nx = |w_drop_nx ? FLUSH : RUN;
    end else if (r_state == FLUSH && bus.imem_rsp_valid) begin
      w_drop_nx  = r_drop - CW'(1);
      w_state_nx = |w_drop_nx ? FLUSH : RUN;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= RUN;
    else r_state <= w_state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_pc         <= RESET_PC;
      r_out        <= '0;
      r_drop       <= '0;
      r_misaligned <= 1'b0;
    end else begin
      r_pc         <= i_pc_new ? {w_target[31:2], 2'b00} : w_fire ? r_pc + INSTR_BYTES : r_pc;
      r_out        <= r_out + CW'(w_fire) - CW'(bus.imem_rsp_valid);
      r_drop       <= w_drop_nx;
      r_misaligned <= i_pc_new & w_target[1];
    end
  fetch_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_pcq (
    .clk(clk), .rst_n(rst_n), .i_push(w_fire), .i_pop(w_push), .i_flush(i_pc_new),
    .i_data(r_pc), .o_data(w_rsp_pc), .o_full(w_pcq_full), .o_empty(w_pcq_empty), .o_count(w_pcq_count)
  );
  fetch_fifo #(.DEPTH(FIFO_DEPTH), .W(64)) u_fifo (
    .clk(clk), .rst_n(rst_n), .i_push(w_push), .i_pop(w_pop), .i_flush(i_pc_new),
    .i_data({w_rsp_pc, bus.imem_rsp_data}), .o_data({bus.if_pc, bus.if_instr}),
    .o_full(w_full), .o_empty(w_empty), .o_count(w_count)
  );
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed vectors and hand-written redirect/reset sequences for fetch_pc_unit
module tb_fetch_pc_unit;
  localparam int D = 2;
  typedef struct {
    logic [31:0] base;
    logic [31:0] off;
    logic        jalr;
    logic [31:0] addr;
    logic [31:0] nxt;
    logic        mis;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pc_new = 1'b0;
  logic jalr = 1'b0;
  logic fetch_en = 1'b1;
  logic rsp_en = 1'b1;
  logic mis;
  logic [31:0] pc_base = '0;
  logic [31:0] pc_offset = '0;
  logic [31:0] exp_pc = 32'h100;
  logic [31:0] q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int n_del = 0;
  int cyc = 0;
  int first_del = -1;
  vec_t vt[9];
  fetch_pc_unit_if bus();
  always #5 clk = ~clk;
  fetch_pc_unit #(.RESET_PC(32'h100), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .i_pc_new(pc_new), .i_pc_base(pc_base), .i_pc_offset(pc_offset),
    .i_jalr(jalr), .i_fetch_en(fetch_en), .o_target_misaligned(mis), .bus(bus)
  );
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  // one clock: memory answers the oldest accepted request, then outputs are sampled before the edge
  task automatic tick();
    bus.imem_rsp_valid = rsp_en && q.size() > 0;
    bus.imem_rsp_data  = bus.imem_rsp_valid ? instr_of(q[0]) : 32'h0;
    #1;
    chk("credit_invariant", 32'(q.size() + int'(dut.w_count) <= D), 1);
    if (pc_new) begin
      chk("redirect_no_req", bus.imem_req_valid, 0);
      chk("redirect_no_if", bus.if_valid, 0);
    end
    if (!fetch_en) chk("fetch_en_off_no_req", bus.imem_req_valid, 0);
    if (bus.imem_rsp_valid) void'(q.pop_front());
    if (bus.imem_req_valid && bus.imem_req_ready) q.push_back(bus.imem_req_addr);
    if (bus.if_valid && bus.if_ready) begin
      chk("if_pc", bus.if_pc, exp_pc);
      chk("if_instr", bus.if_instr, instr_of(exp_pc));
      exp_pc += 32'd4;
      n_del++;
      if (first_del < 0) first_del = cyc;
    end
    cyc++;
    @(negedge clk);
  endtask
  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask
  task automatic redirect(input logic [31:0] b, input logic [31:0] o, input logic j, input logic [31:0] tgt);
    pc_new = 1'b1;
    pc_base = b;
    pc_offset = o;
    jalr = j;
    tick();
    pc_new = 1'b0;
    jalr = 1'b0;
    exp_pc = tgt;
  endtask
  initial begin
    int n0;
    vt[0] = '{32'h0000_0200, 32'h0000_0040, 1'b0, 32'h0000_0240, 32'h0000_0244, 1'b0};
    vt[1] = '{32'h0000_0301, 32'h0000_0000, 1'b1, 32'h0000_0300, 32'h0000_0304, 1'b0};
    vt[2] = '{32'h0000_0302, 32'h0000_0000, 1'b1, 32'h0000_0300, 32'h0000_0304, 1'b1};
    vt[3] = '{32'h0000_1000, 32'hFFFF_FFF0, 1'b0, 32'h0000_0FF0, 32'h0000_0FF4, 1'b0};
    vt[4] = '{32'hFFFF_FFF0, 32'h0000_000C, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0};
    vt[5] = '{32'hFFFF_FFFC, 32'h0000_0008, 1'b0, 32'h0000_0004, 32'h0000_0008, 1'b0};
    vt[6] = '{32'h0000_0500, 32'h0000_0007, 1'b1, 32'h0000_0504, 32'h0000_0508, 1'b1};
    vt[7] = '{32'h0000_0500, 32'h0000_0003, 1'b0, 32'h0000_0500, 32'h0000_0504, 1'b1};
    vt[8] = '{32'h0000_0601, 32'h0000_0000, 1'b0, 32'h0000_0600, 32'h0000_0604, 1'b0};
    bus.imem_req_ready = 1'b1;
    bus.if_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data = '0;
    // reset state, with fetch_en already high
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_valid", bus.imem_req_valid, 0);
    chk("rst_if_valid", bus.if_valid, 0);
    chk("rst_misaligned", mis, 0);
    chk("rst_req_addr", bus.imem_req_addr, 32'h100);
    @(negedge clk);
    rst_n = 1'b1;
    // sequential fetch from RESET_PC
    ticks(6);
    chk("first_delivery_cycle", first_del, 2);
    chk("seq_delivered", 32'(n_del >= 3), 1);
    fetch_en = 1'b0;
    ticks(4);
    fetch_en = 1'b1;
    // decode backpressure
    bus.if_ready = 1'b0;
    n0 = n_del;
    ticks(6);
    #1;
    chk("bp_req_stalled", bus.imem_req_valid, 0);
    chk("bp_if_valid", bus.if_valid, 1);
    chk("bp_head_pc", bus.if_pc, exp_pc);
    chk("bp_no_delivery", n_del, n0);
    bus.if_ready = 1'b1;
    ticks(8);
    chk("bp_resumed", 32'(n_del >= n0 + 4), 1);
    // redirect with two stale requests outstanding
    rsp_en = 1'b0;
    ticks(4);
    chk("pre_redirect_outstanding", q.size(), 2);
    rsp_en = 1'b0;
    redirect(32'h200, 32'h40, 1'b0, 32'h240);
    #1;
    chk("drop_cnt_two", dut.r_drop, 2);
    rsp_en = 1'b1;
    n0 = n_del;
    ticks(8);
    chk("redirect_delivered", 32'(n_del > n0), 1);
    chk("drop_cnt_cleared", dut.r_drop, 0);
    // table of redirect targets
    foreach (vt[i]) begin
      redirect(vt[i].base, vt[i].off, vt[i].jalr, vt[i].addr);
      #1;
      chk("tbl_req_valid", bus.imem_req_valid, 1);
      chk("tbl_req_addr", bus.imem_req_addr, vt[i].addr);
      chk("tbl_misaligned", mis, vt[i].mis);
      tick();
      #1;
      chk("tbl_next_addr", bus.imem_req_addr, vt[i].nxt);
      chk("tbl_mis_cleared", mis, 0);
    end
    ticks(4);
    // back-to-back redirects while flushing
    rsp_en = 1'b0;
    ticks(4);
    chk("b2b_outstanding", q.size(), 2);
    redirect(32'h400, 32'h0, 1'b0, 32'h400);
    redirect(32'h7F0, 32'h10, 1'b0, 32'h800);
    #1;
    chk("b2b_drop_cnt", dut.r_drop, 2);
    rsp_en = 1'b1;
    n0 = n_del;
    ticks(10);
    chk("b2b_delivered", 32'(n_del > n0), 1);
    chk("b2b_drop_cleared", dut.r_drop, 0);
    // asynchronous reset in the middle of a flush
    rsp_en = 1'b0;
    ticks(4);
    redirect(32'h902, 32'h0, 1'b0, 32'h900);
    #1;
    chk("pre_reset_misaligned", mis, 1);
    chk("pre_reset_drop", dut.r_drop, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_req_valid", bus.imem_req_valid, 0);
    chk("async_rst_if_valid", bus.if_valid, 0);
    chk("async_rst_misaligned", mis, 0);
    chk("async_rst_req_addr", bus.imem_req_addr, 32'h100);
    chk("async_rst_drop", dut.r_drop, 0);
    q.delete();
    rsp_en = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_pc = 32'h100;
    cyc = 0;
    first_del = -1;
    ticks(6);
    chk("post_reset_first_delivery", first_del, 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
